// File: rtl/operand_fetch_pipe_pkg.sv
// Shared definitions for the operand fetch stage: default widths,
// instruction field layout and control-word bit positions.
package operand_fetch_pipe_pkg;

  // Default geometry of the stage.
  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 16;
  localparam int PC_W_DEF = 4;

  // Instruction and control word widths.
  localparam int INSTR_W = 16;
  localparam int CTRL_W  = 8;

  // Instruction field positions (all register fields are 4 bits wide).
  localparam int OPC_LSB = 0;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 8;
  localparam int RD_LSB  = 12;
  localparam int IMM_LSB = 8;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;

  // Control word bits.
  localparam int CTRL_REG_WRITE  = 6;
  localparam int CTRL_RD_SEL_LSB = 0;
  localparam int CTRL_RD_SEL_W   = 3;

  // The destination comes from the rd field when any rd-select bit is set,
  // otherwise the rs1 field doubles as the destination.
  function automatic logic rd_sel_active(input logic [CTRL_W-1:0] ctrl);
    return |ctrl[CTRL_RD_SEL_LSB +: CTRL_RD_SEL_W];
  endfunction

endpackage

// File: rtl/operand_fetch_pipe_regfile_bypass.sv
// Register array with two read ports and a write-through bypass, so a
// writeback in the current cycle is visible to a same-cycle read.
module regfile_bypass
  import operand_fetch_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  localparam int RA_W = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [RA_W-1:0] ra_a,
  input  logic [RA_W-1:0] ra_b,
  output logic [XLEN-1:0] rd_a,
  output logic [XLEN-1:0] rd_b
);

  logic [XLEN-1:0] mem_q [NREG];

  // Array write: every register clears in reset, and a writeback arriving
  // during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wb_en) begin
      mem_q[wb_addr] <= wb_data;
    end
  end

  // Read ports: the in-flight writeback takes precedence over stored data.
  always_comb begin
    rd_a = mem_q[ra_a];
    rd_b = mem_q[ra_b];
    if (wb_en && (wb_addr == ra_a)) rd_a = wb_data;
    if (wb_en && (wb_addr == ra_b)) rd_b = wb_data;
  end

endmodule

// File: rtl/operand_fetch_pipe.sv
// Operand fetch stage: reads rs1/rs2, forwards from EX and WB, stalls on a
// load-use hazard, and presents one registered bundle with a valid/ready
// handshake on both sides.
module operand_fetch_pipe
  import operand_fetch_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int PC_W = PC_W_DEF,
  localparam int RA_W = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [CTRL_W-1:0]  ctrl_in,
  input  logic               wb_en,
  input  logic [RA_W-1:0]    wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               ex_valid,
  input  logic               ex_is_load,
  input  logic [RA_W-1:0]    ex_rd,
  input  logic [XLEN-1:0]    ex_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [IMM_W-1:0]   out_imm,
  output logic [XLEN-1:0]    out_op_a,
  output logic [XLEN-1:0]    out_op_b,
  output logic               out_flag,
  output logic [RA_W-1:0]    out_rd
);

  logic [RA_W-1:0] rs1, rs2, rd_field;
  logic [XLEN-1:0] rf_a, rf_b;
  logic [XLEN-1:0] op_a_d, op_b_d;
  logic [RA_W-1:0] rd_d;
  logic            hazard, accept;

  logic            out_valid_q;
  logic [PC_W-1:0] out_pc_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [IMM_W-1:0]  out_imm_q;
  logic [XLEN-1:0] out_op_a_q, out_op_b_q;
  logic            out_flag_q;
  logic [RA_W-1:0] out_rd_q;

  // The opcode is carried only inside out_ctrl; this stage never decodes it.
  logic unused_opcode;
  assign unused_opcode = ^instr_in[OPC_LSB +: FIELD_W];

  assign rs1      = instr_in[RS1_LSB +: RA_W];
  assign rs2      = instr_in[RS2_LSB +: RA_W];
  assign rd_field = instr_in[RD_LSB  +: RA_W];

  regfile_bypass #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .ra_a    (rs1),
    .ra_b    (rs2),
    .rd_a    (rf_a),
    .rd_b    (rf_b)
  );

  // Handshake: a load in EX whose destination matches either source cannot
  // forward yet, so the instruction is refused until the load leaves EX.
  always_comb begin
    hazard   = ex_valid && ex_is_load && ((ex_rd == rs1) || (ex_rd == rs2));
    in_ready = rst_n && (!out_valid_q || out_ready) && !hazard && !flush;
    accept   = in_valid && in_ready;
  end

  // Forwarding: a non-load EX result beats the WB bypass already folded
  // into the regfile read.
  always_comb begin
    op_a_d = rf_a;
    op_b_d = rf_b;
    if (ex_valid && !ex_is_load && (ex_rd == rs1)) op_a_d = ex_data;
    if (ex_valid && !ex_is_load && (ex_rd == rs2)) op_b_d = ex_data;
    rd_d = rd_sel_active(ctrl_in) ? rd_field : rs1;
  end

  // Output register: flush wins, a new bundle loads on accept, a consumed
  // bundle with nothing behind it becomes a bubble, otherwise everything holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_ctrl_q  <= '0;
      out_imm_q   <= '0;
      out_op_a_q  <= '0;
      out_op_b_q  <= '0;
      out_flag_q  <= 1'b0;
      out_rd_q    <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_pc_q    <= pc_in;
      out_ctrl_q  <= ctrl_in;
      out_imm_q   <= instr_in[IMM_LSB +: IMM_W];
      out_op_a_q  <= op_a_d;
      out_op_b_q  <= op_b_d;
      out_flag_q  <= (op_a_d == op_b_d);
      out_rd_q    <= rd_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_imm   = out_imm_q;
  assign out_op_a  = out_op_a_q;
  assign out_op_b  = out_op_b_q;
  assign out_flag  = out_flag_q;
  assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_operand_fetch_pipe.sv
// Directed bench for operand_fetch_pipe: a table of single-cycle vectors
// followed by hand-written backpressure and flush sequences.
module tb_operand_fetch_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  pc_in;
  logic [15:0] instr_in;
  logic [7:0]  ctrl_in;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [63:0] wb_data;
  logic        ex_valid;
  logic        ex_is_load;
  logic [3:0]  ex_rd;
  logic [63:0] ex_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_pc;
  logic [7:0]  out_ctrl;
  logic [7:0]  out_imm;
  logic [63:0] out_op_a;
  logic [63:0] out_op_b;
  logic        out_flag;
  logic [3:0]  out_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pc_in      (pc_in),
    .instr_in   (instr_in),
    .ctrl_in    (ctrl_in),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .ex_data    (ex_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_ctrl   (out_ctrl),
    .out_imm    (out_imm),
    .out_op_a   (out_op_a),
    .out_op_b   (out_op_b),
    .out_flag   (out_flag),
    .out_rd     (out_rd)
  );

  typedef struct {
    logic        iv;
    logic [3:0]  pc;
    logic [15:0] instr;
    logic [7:0]  ctrl;
    logic        wbe;
    logic [3:0]  wba;
    logic [63:0] wbd;
    logic        exv;
    logic        exl;
    logic [3:0]  exr;
    logic [63:0] exd;
    logic        ordy;
    logic        e_rdy;
    logic        e_val;
    logic [63:0] e_a;
    logic [63:0] e_b;
    logic        e_flag;
    logic [3:0]  e_rd;
    logic [3:0]  e_pc;
    logic [7:0]  e_ctrl;
    logic [7:0]  e_imm;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic iv, input logic [3:0] pc, input logic [15:0] instr, input logic [7:0] ctrl,
    input logic wbe, input logic [3:0] wba, input logic [63:0] wbd,
    input logic exv, input logic exl, input logic [3:0] exr, input logic [63:0] exd,
    input logic ordy, input logic e_rdy, input logic e_val,
    input logic [63:0] e_a, input logic [63:0] e_b, input logic e_flag,
    input logic [3:0] e_rd, input logic [3:0] e_pc, input logic [7:0] e_ctrl, input logic [7:0] e_imm);
    vec_t v;
    v.iv = iv; v.pc = pc; v.instr = instr; v.ctrl = ctrl;
    v.wbe = wbe; v.wba = wba; v.wbd = wbd;
    v.exv = exv; v.exl = exl; v.exr = exr; v.exd = exd;
    v.ordy = ordy; v.e_rdy = e_rdy; v.e_val = e_val;
    v.e_a = e_a; v.e_b = e_b; v.e_flag = e_flag;
    v.e_rd = e_rd; v.e_pc = e_pc; v.e_ctrl = e_ctrl; v.e_imm = e_imm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid   = v.iv;
    pc_in      = v.pc;
    instr_in   = v.instr;
    ctrl_in    = v.ctrl;
    wb_en      = v.wbe;
    wb_addr    = v.wba;
    wb_data    = v.wbd;
    ex_valid   = v.exv;
    ex_is_load = v.exl;
    ex_rd      = v.exr;
    ex_data    = v.exd;
    out_ready  = v.ordy;
    flush      = 1'b0;
  endtask

  task automatic check_bundle(input string tag, input logic val, input logic [63:0] a,
                              input logic [63:0] b, input logic [3:0] pc);
    chk({tag, " out_valid"}, 64'(out_valid), 64'(val));
    chk({tag, " out_op_a"},  out_op_a, a);
    chk({tag, " out_op_b"},  out_op_b, b);
    chk({tag, " out_pc"},    64'(out_pc), 64'(pc));
  endtask

  initial begin
    // Table: expected values assume the vectors run back to back after reset.
    //            iv pc instr    ctrl   wbe wba wbd     exv exl exr exd     ordy rdy val a      b      flg rd pc  ctrl   imm
    vecs[0]  = mk(1, 1, 'h0030, 'h00, 0, 0, 0,      0, 0, 0, 0,      1,   1,  1,  0,     0,     1,  3, 1,  'h00, 'h00);
    vecs[1]  = mk(1, 2, 'h0050, 'h00, 1, 5, 'hAA,   0, 0, 0, 0,      1,   1,  1,  'hAA,  0,     0,  5, 2,  'h00, 'h00);
    vecs[2]  = mk(1, 3, 'h0550, 'h00, 1, 5, 'h22,   1, 0, 5, 'h11,   1,   1,  1,  'h11,  'h11,  1,  5, 3,  'h00, 'h05);
    vecs[3]  = mk(1, 4, 'h0050, 'h00, 0, 0, 0,      0, 0, 0, 0,      1,   1,  1,  'h22,  0,     0,  5, 4,  'h00, 'h00);
    vecs[4]  = mk(1, 5, 'h0010, 'h00, 1, 1, 7,      0, 0, 0, 0,      1,   1,  1,  7,     0,     0,  1, 5,  'h00, 'h00);
    vecs[5]  = mk(1, 6, 'h9210, 'h02, 1, 2, 7,      0, 0, 0, 0,      1,   1,  1,  7,     7,     1,  9, 6,  'h02, 'h92);
    vecs[6]  = mk(1, 7, 'h9210, 'h00, 0, 0, 0,      0, 0, 0, 0,      1,   1,  1,  7,     7,     1,  1, 7,  'h00, 'h92);
    vecs[7]  = mk(1, 8, 'h9210, 'h40, 0, 0, 0,      1, 0, 2, 'h55,   1,   1,  1,  7,     'h55,  0,  1, 8,  'h40, 'h92);
    vecs[8]  = mk(1, 9, 'h3021, 'h04, 0, 0, 0,      0, 0, 0, 0,      1,   1,  1,  7,     0,     0,  3, 9,  'h04, 'h30);
    vecs[9]  = mk(1, 3, 'h0020, 'h00, 0, 0, 0,      0, 0, 0, 0,      1,   1,  1,  7,     0,     0,  2, 3,  'h00, 'h00);
    vecs[10] = mk(1, 10,'h0210, 'h00, 0, 0, 0,      1, 1, 2, 'h77,   1,   0,  0,  7,     0,     0,  2, 3,  'h00, 'h00);
    vecs[11] = mk(1, 10,'h0210, 'h00, 0, 0, 0,      0, 0, 0, 0,      1,   1,  1,  7,     7,     1,  1, 10, 'h00, 'h02);
    vecs[12] = mk(0, 0, 'h0000, 'h00, 0, 0, 0,      0, 0, 0, 0,      1,   1,  0,  7,     7,     1,  1, 10, 'h00, 'h02);

    // Reset for two cycles with a writeback to r3 that must be discarded.
    rst_n = 1'b0;
    drive(mk(1, 5, 'h0030, 'h07, 1, 3, 'hDEAD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("reset%0d in_ready", c), 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      check_bundle($sformatf("reset%0d", c), 1'b0, 0, 0, 0);
      chk($sformatf("reset%0d out_flag", c), 64'(out_flag), 64'(0));
      chk($sformatf("reset%0d out_rd", c),   64'(out_rd),   64'(0));
      chk($sformatf("reset%0d out_ctrl", c), 64'(out_ctrl), 64'(0));
      chk($sformatf("reset%0d out_imm", c),  64'(out_imm),  64'(0));
    end
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_rdy));
      @(posedge clk); #1;
      check_bundle($sformatf("v%0d", i), vecs[i].e_val, vecs[i].e_a, vecs[i].e_b, vecs[i].e_pc);
      chk($sformatf("v%0d out_flag", i), 64'(out_flag), 64'(vecs[i].e_flag));
      chk($sformatf("v%0d out_rd", i),   64'(out_rd),   64'(vecs[i].e_rd));
      chk($sformatf("v%0d out_ctrl", i), 64'(out_ctrl), 64'(vecs[i].e_ctrl));
      chk($sformatf("v%0d out_imm", i),  64'(out_imm),  64'(vecs[i].e_imm));
      $display("vector %0d: in_ready=%0b out_valid=%0b op_a=0x%0h op_b=0x%0h flag=%0b rd=%0d",
               i, vecs[i].e_rdy, out_valid, out_op_a, out_op_b, out_flag, out_rd);
    end

    // Load a bundle (r1=7, r2=7) to stall behind.
    drive(mk(1, 11, 'h0210, 'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("bp_load in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    check_bundle("bp_load", 1'b1, 7, 7, 11);
    $display("backpressure load: out_valid=%0b op_a=0x%0h", out_valid, out_op_a);

    // Three cycles of backpressure; r1 is overwritten during the stall but
    // the held bundle must not change.
    for (int c = 0; c < 3; c++) begin
      drive(mk(1, 12, 'h0050, 'h00, (c == 0), 1, 'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      chk($sformatf("bp%0d in_ready", c), 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      check_bundle($sformatf("bp%0d", c), 1'b1, 7, 7, 11);
      chk($sformatf("bp%0d out_flag", c), 64'(out_flag), 64'(1));
      $display("backpressure cycle %0d: out_valid=%0b op_a=0x%0h pc=%0d", c, out_valid, out_op_a, out_pc);
    end

    // Flush while stalled clears the bundle.
    drive(mk(1, 12, 'h0050, 'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    flush = 1'b1;
    #1;
    chk("flush_stall in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    chk("flush_stall out_valid", 64'(out_valid), 64'(0));
    $display("flush while stalled: out_valid=%0b", out_valid);

    // The write made during the stall is visible to the next read of r1.
    drive(mk(1, 12, 'h0010, 'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("after_flush in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    check_bundle("after_flush", 1'b1, 'h99, 0, 12);
    $display("read after stall write: out_valid=%0b op_a=0x%0h", out_valid, out_op_a);

    // Flush dominates acceptance of a valid instruction.
    drive(mk(1, 13, 'h0050, 'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    flush = 1'b1;
    #1;
    chk("flush_accept in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    chk("flush_accept out_valid", 64'(out_valid), 64'(0));
    chk("flush_accept out_pc",    64'(out_pc),    64'(12));
    $display("flush with valid input: out_valid=%0b pc=%0d", out_valid, out_pc);
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
